instruction_fetch_stage: RTL and testbench

Pipelined MIPS fetch stage: owns the program counter, issues word reads to the instruction memory over a ready handshake, and drives the IF/ID pipeline register. The 32-bit instruction it registers is what the decode stage consumes, including the 16-bit immediate field passed to sign extension. It also handles hazard-unit stalls and flushes, and branch/jump redirects, including redirects that arrive while a memory read is still outstanding.

---
 rtl/instruction_fetch_stage.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// MIPS fetch stage: owns the PC, reads instruction memory over a ready handshake
// and loads the IF/ID register, with stall/flush and branch/jump redirect support.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] PC,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a read is outstanding in every cycle IMemReq=1; it
  // completes in the cycle IMemReady=1, with IMemData valid in that same cycle.
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] saved_q, saved_d;
  logic        req_q;
  logic [31:0] instr_q, pc4_q;
  logic        valid_q;
  logic        do_load, do_bubble;
  logic        redirect;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  assign redirect     = BranchTaken | Jump;
  assign redir_target = BranchTaken ? {BranchTarget[31:2], 2'b00}
                                    : {JumpTarget[31:2], 2'b00};
  assign pc_plus4     = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    saved_d   = saved_q;
    do_load   = 1'b0;
    do_bubble = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d   = ST_FETCH;
        do_bubble = !Stall;
      end
      ST_FETCH: begin
        if (redirect && IMemReady) begin
          pc_d      = redir_target;
          do_bubble = 1'b1;
        end else if (redirect) begin
          // Read still in flight: remember where to go once it drains.
          saved_d   = redir_target;
          state_d   = ST_DRAIN;
          do_bubble = !Stall;
        end else if (IMemReady && !Stall) begin
          pc_d    = pc_plus4;
          do_load = 1'b1;
        end else if (!IMemReady) begin
          do_bubble = !Stall;
        end
      end
      ST_DRAIN: begin
        if (redirect) saved_d = redir_target;
        if (IMemReady) begin
          pc_d    = redirect ? redir_target : saved_q;
          state_d = ST_FETCH;
        end
        do_bubble = !Stall;
      end
      default: state_d = ST_BOOT;
    endcase
    if (Flush) begin
      do_load   = 1'b0;
      do_bubble = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      saved_q <= 32'h0;
      req_q   <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
      req_q   <= (state_d != ST_BOOT);
      if (do_bubble) begin
        instr_q <= NOP_WORD;
        pc4_q   <= 32'h0;
        valid_q <= 1'b0;
      end else if (do_load) begin
        instr_q <= IMemData;
        pc4_q   <= pc_plus4;
        valid_q <= 1'b1;
      end
    end
  end

  assign IMemReq          = req_q;
  assign IMemAddr         = pc_q;
  assign PC               = pc_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PCPlus4     = pc4_q;
  assign IFID_Valid       = valid_q;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory returns addr ^ 32'hA5A5_0000.
module tb_instruction_fetch_stage;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemData;
  logic        IMemReady = 1'b0;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] PC;
  logic [1:0]  fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  instruction_fetch_stage dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .IMemReady(IMemReady),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid(IFID_Valid), .PC(PC), .fsm_state(fsm_state)
  );

  always #5 Clk = ~Clk;

  assign IMemData = IMemAddr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({PC, IMemReq, fsm_state} !== {32'h0, 1'b0, ST_BOOT}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: pc=%h req=%b st=%0d, want pc=0 req=0 st=0", PC, IMemReq, fsm_state);
    end
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid} !== {32'h0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ifid: %h %h %b, want 0 0 0", IFID_Instruction, IFID_PCPlus4, IFID_Valid);
    end
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    tick();
    tests_run++;
    if ({fsm_state, IMemReq, PC, IFID_Valid} !== {ST_FETCH, 1'b1, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL boot_exit: st=%0d req=%b pc=%h v=%b, want st=1 req=1 pc=0 v=0", fsm_state, IMemReq, PC, IFID_Valid);
    end
  endtask

  task automatic test_seq_fetch();
    IMemReady = 1'b1;
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0000, 32'h4, 1'b1, 32'h4}) begin
      tests_failed++;
      $display("FAIL seq_first: %h %h %b pc=%h, want a5a50000 4 1 pc=4", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0004, 32'h8, 1'b1, 32'h8}) begin
      tests_failed++;
      $display("FAIL seq_second: %h %h %b pc=%h, want a5a50004 8 1 pc=8", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0004, 32'h8, 1'b1, 32'h8}) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: %h %h %b pc=%h, want a5a50004 8 1 pc=8", i, IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
      end
    end
    Stall = 1'b0;
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0008, 32'hC, 1'b1, 32'hC}) begin
      tests_failed++;
      $display("FAIL stall_release: %h %h %b pc=%h, want a5a50008 c 1 pc=c", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
  endtask

  task automatic test_flush_stall();
    Flush = 1'b1;
    Stall = 1'b1;
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'h0, 32'h0, 1'b0, 32'hC}) begin
      tests_failed++;
      $display("FAIL flush_stall: %h %h %b pc=%h, want 0 0 0 pc=c", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
    Flush = 1'b0;
    Stall = 1'b0;
  endtask

  task automatic test_branch_drain();
    IMemReady = 1'b0;
    BranchTaken = 1'b1;
    BranchTarget = 32'h0000_0102;
    tick();
    tests_run++;
    if ({fsm_state, PC, IMemReq, IFID_Valid} !== {ST_DRAIN, 32'hC, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL branch_enter_drain: st=%0d pc=%h req=%b v=%b, want st=2 pc=c req=1 v=0", fsm_state, PC, IMemReq, IFID_Valid);
    end
    BranchTaken = 1'b0;
    tick();
    tests_run++;
    if ({fsm_state, PC} !== {ST_DRAIN, 32'hC}) begin
      tests_failed++;
      $display("FAIL branch_wait_drain: st=%0d pc=%h, want st=2 pc=c", fsm_state, PC);
    end
    IMemReady = 1'b1;
    tick();
    tests_run++;
    if ({fsm_state, PC, IFID_Valid} !== {ST_FETCH, 32'h100, 1'b0}) begin
      tests_failed++;
      $display("FAIL branch_drain_done: st=%0d pc=%h v=%b, want st=1 pc=100 v=0", fsm_state, PC, IFID_Valid);
    end
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0100, 32'h104, 1'b1, 32'h104}) begin
      tests_failed++;
      $display("FAIL branch_target_word: %h %h %b pc=%h, want a5a50100 104 1 pc=104", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
  endtask

  task automatic test_simultaneous_redirect();
    Jump = 1'b1;
    JumpTarget = 32'h200;
    BranchTaken = 1'b1;
    BranchTarget = 32'h300;
    tick();
    tests_run++;
    if ({PC, IFID_Valid, fsm_state} !== {32'h300, 1'b0, ST_FETCH}) begin
      tests_failed++;
      $display("FAIL branch_priority: pc=%h v=%b st=%0d, want pc=300 v=0 st=1", PC, IFID_Valid, fsm_state);
    end
    Jump = 1'b0;
    BranchTarget = 32'h500;
    IMemReady = 1'b0;
    tick();
    BranchTaken = 1'b0;
    Jump = 1'b1;
    JumpTarget = 32'h400;
    tick();
    Jump = 1'b0;
    IMemReady = 1'b1;
    tick();
    tests_run++;
    if ({PC, fsm_state} !== {32'h400, ST_FETCH}) begin
      tests_failed++;
      $display("FAIL drain_overwrite: pc=%h st=%0d, want pc=400 st=1", PC, fsm_state);
    end
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid} !== {32'hA5A5_0400, 32'h404, 1'b1}) begin
      tests_failed++;
      $display("FAIL drain_target_word: %h %h %b, want a5a50400 404 1", IFID_Instruction, IFID_PCPlus4, IFID_Valid);
    end
  endtask

  task automatic test_wrap();
    Jump = 1'b1;
    JumpTarget = 32'hFFFF_FFFC;
    tick();
    Jump = 1'b0;
    tests_run++;
    if (PC !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_setup: pc=%h, want fffffffc", PC);
    end
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'h5A5A_FFFC, 32'h0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap: %h %h %b pc=%h, want 5a5afffc 0 1 pc=0", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
  endtask

  task automatic test_reset_mid_drain();
    IMemReady = 1'b0;
    BranchTaken = 1'b1;
    BranchTarget = 32'h800;
    tick();
    BranchTaken = 1'b0;
    tests_run++;
    if (fsm_state !== ST_DRAIN) begin
      tests_failed++;
      $display("FAIL rst_drain_setup: st=%0d, want 2", fsm_state);
    end
    Reset_n = 1'b0;
    #2;
    tests_run++;
    if ({PC, IMemReq, fsm_state, IFID_Instruction, IFID_PCPlus4, IFID_Valid} !==
        {32'h0, 1'b0, ST_BOOT, 32'h0, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h req=%b st=%0d ifid=%h %h %b, want all reset", PC, IMemReq, fsm_state, IFID_Instruction, IFID_PCPlus4, IFID_Valid);
    end
    Reset_n = 1'b1;
    tick();
    IMemReady = 1'b1;
    tick();
    tests_run++;
    if ({IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC} !== {32'hA5A5_0000, 32'h4, 1'b1, 32'h4}) begin
      tests_failed++;
      $display("FAIL post_reset_fetch: %h %h %b pc=%h, want a5a50000 4 1 pc=4", IFID_Instruction, IFID_PCPlus4, IFID_Valid, PC);
    end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_stall();
    test_flush_stall();
    test_branch_drain();
    test_simultaneous_redirect();
    test_wrap();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
